// File: rtl/zbt_bitstream_arbiter.sv
// rtl/zbt_bitstream_arbiter.sv - shares one ZBT SRAM port between video and audio bitstream units
// Purpose: round-robin, burst-bounded arbitration with a turnaround gap, registered
//   ZBT pin mux, and a read tag pipe that routes returning read data valids to the issuer.
// Ports:
//   clock, resetn                     clock, asynchronous active-low reset
//   Video_*/Audio_* Request_I         unit wants the ZBT port
//   Video_*/Audio_* Access_O          registered grant (one-hot or zero)
//   Video_*/Audio_* Address/Write_Data/Write_En_I   unit access fields
//   Video_*/Audio_* Read_Valid_O      ZBT_Read_Data_O belongs to this unit's read
//   ZBT_Address_O/Write_Data_O/Write_En_O   registered ZBT pins
//   ZBT_Read_Data_I / ZBT_Read_Data_O ZBT read pins / registered copy to both units
// Option: ZBT_ARB_AUDIO_PRIORITY_EN - audio wins ties and preempts video bursts.
module zbt_bitstream_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 32,
  parameter int VIDEO_BURST  = 16,
  parameter int AUDIO_BURST  = 4,
  parameter int READ_LATENCY = 2,
  parameter int TURN_CYCLES  = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              Video_Request_I,
  output logic              Video_Access_O,
  input  logic [ADDR_W-1:0] Video_Address_I,
  input  logic [DATA_W-1:0] Video_Write_Data_I,
  input  logic              Video_Write_En_I,
  output logic              Video_Read_Valid_O,
  input  logic              Audio_Request_I,
  output logic              Audio_Access_O,
  input  logic [ADDR_W-1:0] Audio_Address_I,
  input  logic [DATA_W-1:0] Audio_Write_Data_I,
  input  logic              Audio_Write_En_I,
  output logic              Audio_Read_Valid_O,
  output logic [DATA_W-1:0] ZBT_Read_Data_O,
  output logic [ADDR_W-1:0] ZBT_Address_O,
  output logic [DATA_W-1:0] ZBT_Write_Data_O,
  output logic              ZBT_Write_En_O,
  input  logic [DATA_W-1:0] ZBT_Read_Data_I
);

  localparam int MAX_BURST = (VIDEO_BURST > AUDIO_BURST) ? VIDEO_BURST : AUDIO_BURST;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam int TURN_W    = $clog2(TURN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  VIDEO_LAST = CNT_W'(VIDEO_BURST - 1);
  localparam logic [CNT_W-1:0]  AUDIO_LAST = CNT_W'(AUDIO_BURST - 1);
  localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT_V, GNT_A, TURN} state_t;

  state_t              state;
  logic                last_audio;     // 1 when audio was served last
  logic [CNT_W-1:0]    burst_cnt;      // granted cycles already completed in this burst
  logic [TURN_W-1:0]   turn_cnt;
  logic                pick_video;
  logic                pick_audio;
  logic                preempt_video;
  // Stage k holds reads whose pin cycle was k cycles ago.
  logic [READ_LATENCY:0] tag_video;
  logic [READ_LATENCY:0] tag_audio;

`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
  assign preempt_video = Audio_Request_I;
`else
  assign preempt_video = 1'b0;
`endif

  always_comb begin
    pick_video = 1'b0;
    pick_audio = 1'b0;
`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
    if (Audio_Request_I)      pick_audio = 1'b1;
    else if (Video_Request_I) pick_video = 1'b1;
`else
    if (Video_Request_I && Audio_Request_I) begin
      pick_video = last_audio;
      pick_audio = ~last_audio;
    end else begin
      pick_video = Video_Request_I;
      pick_audio = Audio_Request_I;
    end
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      Video_Access_O <= 1'b0;
      Audio_Access_O <= 1'b0;
      last_audio     <= 1'b1;
      burst_cnt      <= '0;
      turn_cnt       <= '0;
    end else begin
      case (state)
        GNT_V: begin
          if (burst_cnt == VIDEO_LAST || !Video_Request_I || preempt_video) begin
            state          <= TURN;
            Video_Access_O <= 1'b0;
            last_audio     <= 1'b0;
            burst_cnt      <= '0;
            turn_cnt       <= '0;
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        GNT_A: begin
          if (burst_cnt == AUDIO_LAST || !Audio_Request_I) begin
            state          <= TURN;
            Audio_Access_O <= 1'b0;
            last_audio     <= 1'b1;
            burst_cnt      <= '0;
            turn_cnt       <= '0;
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          // IDLE arbitrates every cycle; TURN arbitrates on its last gap cycle.
          if (state == TURN && turn_cnt != TURN_LAST) begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end else begin
            turn_cnt  <= '0;
            burst_cnt <= '0;
            if (pick_video) begin
              state          <= GNT_V;
              Video_Access_O <= 1'b1;
            end else if (pick_audio) begin
              state          <= GNT_A;
              Audio_Access_O <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ZBT_Address_O      <= '0;
      ZBT_Write_Data_O   <= '0;
      ZBT_Write_En_O     <= 1'b0;
      ZBT_Read_Data_O    <= '0;
      tag_video          <= '0;
      tag_audio          <= '0;
      Video_Read_Valid_O <= 1'b0;
      Audio_Read_Valid_O <= 1'b0;
    end else begin
      if (Video_Access_O) begin
        ZBT_Address_O    <= Video_Address_I;
        ZBT_Write_Data_O <= Video_Write_Data_I;
        ZBT_Write_En_O   <= Video_Write_En_I;
      end else if (Audio_Access_O) begin
        ZBT_Address_O    <= Audio_Address_I;
        ZBT_Write_Data_O <= Audio_Write_Data_I;
        ZBT_Write_En_O   <= Audio_Write_En_I;
      end else begin
        ZBT_Write_En_O <= 1'b0;
      end
      // Tags keep shifting regardless of grant so in-flight reads finish after release.
      tag_video          <= {tag_video[READ_LATENCY-1:0], Video_Access_O & ~Video_Write_En_I};
      tag_audio          <= {tag_audio[READ_LATENCY-1:0], Audio_Access_O & ~Audio_Write_En_I};
      Video_Read_Valid_O <= tag_video[READ_LATENCY];
      Audio_Read_Valid_O <= tag_audio[READ_LATENCY];
      ZBT_Read_Data_O    <= ZBT_Read_Data_I;
    end
  end

endmodule

// File: tb/tb_zbt_bitstream_arbiter.sv
// tb/tb_zbt_bitstream_arbiter.sv - self-checking bench for zbt_bitstream_arbiter
module tb_zbt_bitstream_arbiter;
  localparam int AW = 19, DW = 32, VB = 16, AB = 4, RL = 2, TC = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn = 1'b1;
  logic          Video_Request_I = 0, Video_Write_En_I = 0, Audio_Request_I = 0, Audio_Write_En_I = 0;
  logic [AW-1:0] Video_Address_I = '0, Audio_Address_I = '0;
  logic [DW-1:0] Video_Write_Data_I = '0, Audio_Write_Data_I = '0, ZBT_Read_Data_I = '0;
  logic          Video_Access_O, Audio_Access_O, Video_Read_Valid_O, Audio_Read_Valid_O, ZBT_Write_En_O;
  logic [AW-1:0] ZBT_Address_O;
  logic [DW-1:0] ZBT_Read_Data_O, ZBT_Write_Data_O;

  zbt_bitstream_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VIDEO_BURST(VB), .AUDIO_BURST(AB),
                          .READ_LATENCY(RL), .TURN_CYCLES(TC)) dut (
    .clock(clock), .resetn(resetn),
    .Video_Request_I(Video_Request_I), .Video_Access_O(Video_Access_O),
    .Video_Address_I(Video_Address_I), .Video_Write_Data_I(Video_Write_Data_I),
    .Video_Write_En_I(Video_Write_En_I), .Video_Read_Valid_O(Video_Read_Valid_O),
    .Audio_Request_I(Audio_Request_I), .Audio_Access_O(Audio_Access_O),
    .Audio_Address_I(Audio_Address_I), .Audio_Write_Data_I(Audio_Write_Data_I),
    .Audio_Write_En_I(Audio_Write_En_I), .Audio_Read_Valid_O(Audio_Read_Valid_O),
    .ZBT_Read_Data_O(ZBT_Read_Data_O), .ZBT_Address_O(ZBT_Address_O),
    .ZBT_Write_Data_O(ZBT_Write_Data_O), .ZBT_Write_En_O(ZBT_Write_En_O),
    .ZBT_Read_Data_I(ZBT_Read_Data_I)
  );

  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wd; } op_t;
  typedef struct { int due; int owner; logic [DW-1:0] data; } exp_t;

  op_t           vq[$], aq[$];      // pending accesses of each unit
  exp_t          eq[$];             // expected read valids in issue order
  logic [AW-1:0] pin_hist[$];       // SRAM model: pin address history, [0] = this cycle
  int            checks = 0, failures = 0, t = 0;
  // Reference arbiter: owner 0 none / 1 video / 2 audio.
  int            m_owner, m_cnt, m_turn, m_last;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          e_we;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return 32'hA5A50000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_owner = 0; m_cnt = 0; m_turn = 0; m_last = 2;
    e_addr = '0; e_wd = '0; e_we = 1'b0;
    eq.delete();
  endtask

  function automatic int pick(input logic vr, input logic ar);
`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
    if (ar) return 2;
    return vr ? 1 : 0;
`else
    if (vr && ar) return (m_last == 1) ? 2 : 1;
    return vr ? 1 : (ar ? 2 : 0);
`endif
  endfunction

  // Advance the reference by one clock edge using the inputs of the current cycle.
  task automatic model_edge;
    logic req, pre;
    int   lim;
    if (m_owner == 1) begin
      e_addr = Video_Address_I; e_wd = Video_Write_Data_I; e_we = Video_Write_En_I;
      if (!Video_Write_En_I) eq.push_back('{t + RL + 2, 1, rdata_of(Video_Address_I)});
    end else if (m_owner == 2) begin
      e_addr = Audio_Address_I; e_wd = Audio_Write_Data_I; e_we = Audio_Write_En_I;
      if (!Audio_Write_En_I) eq.push_back('{t + RL + 2, 2, rdata_of(Audio_Address_I)});
    end else begin
      e_we = 1'b0;
    end
    if (m_owner != 0) begin
      m_cnt++;
      req = (m_owner == 1) ? Video_Request_I : Audio_Request_I;
      lim = (m_owner == 1) ? VB : AB;
      pre = 1'b0;
`ifdef ZBT_ARB_AUDIO_PRIORITY_EN
      pre = (m_owner == 1) && Audio_Request_I;
`endif
      if (m_cnt == lim || !req || pre) begin
        m_last = m_owner; m_owner = 0; m_turn = TC;
      end
    end else if (m_turn > 1) begin
      m_turn--;
    end else begin
      m_turn = 0; m_cnt = 0;
      m_owner = pick(Video_Request_I, Audio_Request_I);
    end
  endtask

  task automatic check_cycle;
    logic ev, ea;
    logic [DW-1:0] ed;
    exp_t x;
    ev = 1'b0; ea = 1'b0; ed = '0;
    if (eq.size() > 0 && eq[0].due == t) begin
      x = eq.pop_front();
      ev = (x.owner == 1); ea = (x.owner == 2); ed = x.data;
    end
    chk("gnt_v", 64'(Video_Access_O), 64'(m_owner == 1));
    chk("gnt_a", 64'(Audio_Access_O), 64'(m_owner == 2));
    chk("pin_we", 64'(ZBT_Write_En_O), 64'(e_we));
    chk("pin_addr", 64'(ZBT_Address_O), 64'(e_addr));
    chk("pin_wd", 64'(ZBT_Write_Data_O), 64'(e_wd));
    chk("valid_v", 64'(Video_Read_Valid_O), 64'(ev));
    chk("valid_a", 64'(Audio_Read_Valid_O), 64'(ea));
    if (ev || ea) chk("rdata", 64'(ZBT_Read_Data_O), 64'(ed));
  endtask

  // Each unit presents one queued access per granted cycle and drops its request on the last one.
  task automatic drive_units(input bit rnd);
    op_t o;
    if (m_owner == 1 && vq.size() > 0) begin
      o = vq.pop_front();
      Video_Address_I = o.addr; Video_Write_Data_I = o.wd; Video_Write_En_I = o.we;
      Video_Request_I = (vq.size() > 0);
    end else begin
      Video_Address_I = AW'($urandom); Video_Write_Data_I = $urandom; Video_Write_En_I = 1'b0;
      Video_Request_I = (vq.size() > 0) && !(rnd && $urandom_range(0, 3) == 0);
    end
    if (m_owner == 2 && aq.size() > 0) begin
      o = aq.pop_front();
      Audio_Address_I = o.addr; Audio_Write_Data_I = o.wd; Audio_Write_En_I = o.we;
      Audio_Request_I = (aq.size() > 0);
    end else begin
      Audio_Address_I = AW'($urandom); Audio_Write_Data_I = $urandom; Audio_Write_En_I = 1'b0;
      Audio_Request_I = (aq.size() > 0) && !(rnd && $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic sram_update;
    pin_hist.push_front(ZBT_Address_O);
    if (pin_hist.size() > RL + 1) void'(pin_hist.pop_back());
    ZBT_Read_Data_I = (pin_hist.size() > RL) ? rdata_of(pin_hist[RL]) : '0;
  endtask

  task automatic step(input bit rnd);
    op_t o;
    model_edge();
    @(posedge clock); #1; t++;
    check_cycle();
    if (rnd) begin
      if ($urandom_range(0, 2) == 0 && vq.size() < 6) begin
        o.addr = AW'($urandom); o.we = 1'($urandom); o.wd = $urandom; vq.push_back(o);
      end
      if ($urandom_range(0, 2) == 0 && aq.size() < 6) begin
        o.addr = AW'($urandom); o.we = 1'($urandom); o.wd = $urandom; aq.push_back(o);
      end
    end
    sram_update();
    drive_units(rnd);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0; #1;
    chk({tag, "_gnt"}, 64'({Video_Access_O, Audio_Access_O}), 64'(0));
    chk({tag, "_valid"}, 64'({Video_Read_Valid_O, Audio_Read_Valid_O}), 64'(0));
    chk({tag, "_we"}, 64'(ZBT_Write_En_O), 64'(0));
    chk({tag, "_addr"}, 64'(ZBT_Address_O), 64'(0));
    chk({tag, "_data"}, 64'({ZBT_Write_Data_O, ZBT_Read_Data_O}), 64'(0));
    vq.delete(); aq.delete(); pin_hist.delete();
    model_reset();
    Video_Request_I = 0; Audio_Request_I = 0; Video_Write_En_I = 0; Audio_Write_En_I = 0;
    repeat (2) @(posedge clock);
    #1; resetn = 1'b1;
    sram_update();
    drive_units(1'b0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((vq.size() > 0 || aq.size() > 0 || eq.size() > 0 || m_owner != 0) && n < 400) begin
      step(1'b0); n++;
    end
    chk("drain_bound", 64'(n < 400), 64'(1));
    repeat (TC + 2) step(1'b0);
  endtask

  task automatic load(input int unit, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    op_t o;
    o.addr = a; o.we = we; o.wd = wd;
    if (unit == 1) vq.push_back(o); else aq.push_back(o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pin, first_val, vcnt, acnt, wcnt, order[$];
    #1;
    do_reset("reset");

    // 1: simultaneous requests from reset -> video 16, gap, audio 4, gap, video.
    for (int i = 0; i < 20; i++) load(1, AW'(32'h100 + i), 1'b0, '0);
    for (int i = 0; i < 8; i++) load(2, AW'(32'h200 + i), 1'b0, '0);
    drive_units(1'b0);
    for (int i = 1; i <= 23; i++) begin
      step(1'b0);
      chk($sformatf("t1_gv_c%0d", i), 64'(Video_Access_O), 64'(i <= 16 || i == 23));
      chk($sformatf("t1_ga_c%0d", i), 64'(Audio_Access_O), 64'(i >= 18 && i <= 21));
    end
    drain();

    // 2: video reads 0x10..0x13, valids 3 cycles after the first pin address.
    for (int i = 0; i < 4; i++) load(1, AW'(32'h10 + i), 1'b0, '0);
    drive_units(1'b0);
    first_pin = -1; first_val = -1; vcnt = 0; acnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (first_pin < 0 && ZBT_Address_O == AW'(32'h10)) first_pin = t;
      if (Video_Read_Valid_O) begin
        if (first_val < 0) first_val = t;
        vcnt++;
      end
      if (Audio_Read_Valid_O) acnt++;
    end
    chk("t2_latency", 64'(first_val - first_pin), 64'(3));
    chk("t2_vcount", 64'(vcnt), 64'(4));
    chk("t2_acount", 64'(acnt), 64'(0));
    drain();

    // 3: single audio write at the top address.
    load(2, 19'h7FFFF, 1'b1, 32'hDEADBEEF);
    drive_units(1'b0);
    wcnt = 0; vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (ZBT_Write_En_O) begin
        wcnt++;
        chk("t3_addr", 64'(ZBT_Address_O), 64'(19'h7FFFF));
        chk("t3_wdata", 64'(ZBT_Write_Data_O), 64'(32'hDEADBEEF));
      end
      if (Video_Read_Valid_O || Audio_Read_Valid_O) vcnt++;
    end
    chk("t3_we_cycles", 64'(wcnt), 64'(1));
    chk("t3_no_valid", 64'(vcnt), 64'(0));
    drain();

    // 4: video read then audio read in back-to-back grants; valids in issue order.
    load(1, AW'(32'h333), 1'b0, '0);
    load(2, AW'(32'h444), 1'b0, '0);
    drive_units(1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (Video_Read_Valid_O) order.push_back(1);
      if (Audio_Read_Valid_O) order.push_back(2);
    end
    chk("t4_count", 64'(order.size()), 64'(2));
    if (order.size() == 2) begin
      chk("t4_first", 64'(order[0]), 64'(1));
      chk("t4_second", 64'(order[1]), 64'(2));
    end
    drain();

    // 5: reset mid video burst with reads in flight.
    for (int i = 0; i < 10; i++) load(1, AW'(32'h500 + i), 1'b0, '0);
    drive_units(1'b0);
    repeat (4) step(1'b0);
    do_reset("t5_reset");
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (Video_Read_Valid_O || Audio_Read_Valid_O) vcnt++;
    end
    chk("t5_no_valid", 64'(vcnt), 64'(0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) step(1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
